// File: rtl/fetch_unit_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int          FQ_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
interface fetch_unit_if;
    // Handshakes: imem transfer occurs on imem_req && imem_ready (address held until then);
    // imem_rvalid is a one-cycle response pulse; decode transfer occurs on instr_valid && instr_ready.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rdata, imem_rvalid, redirect_en, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rdata, imem_rvalid, redirect_en, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries with a single-cycle flush.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fq_entry_t                i_push_data,
    input  logic                     i_pop,
    output fq_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_pop;

    assign w_do_pop = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Request gating upstream must make this unreachable.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) i_push |-> !o_full);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding a small fetch queue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    fetch_unit_if.master                bus,
    output fetch_state_t                o_state,
    output logic [31:0]                 o_fetch_pc,
    output logic [$clog2(FQ_DEPTH):0]   o_count
);
    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;
    logic         w_imem_req;
    logic         w_accept;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    fq_entry_t    w_push_data;
    fq_entry_t    w_head;

    assign w_accept    = w_imem_req && bus.imem_ready;
    assign w_pop       = !w_empty && bus.instr_ready && !bus.redirect_en;
    assign w_push_data = '{instr: bus.imem_rdata, pc: r_req_pc};

    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                w_imem_req = rst && !w_full && !bus.redirect_en;
                if (w_imem_req && bus.imem_ready) w_next_state = WAIT;
            end
            WAIT: begin
                // A redirect racing the response discards it; otherwise the late response must be dropped.
                if (bus.imem_rvalid) begin
                    w_push       = !bus.redirect_en;
                    w_next_state = IDLE;
                end else if (bus.redirect_en) begin
                    w_next_state = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else begin
            r_state <= w_next_state;
            if (bus.redirect_en) begin
                r_fetch_pc <= bus.redirect_pc & ~32'h3;
            end else if (w_accept) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.redirect_en),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (o_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.imem_req    = w_imem_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = !w_empty;
    assign bus.instr       = w_head.instr;
    assign bus.instr_pc    = w_head.pc;
    assign o_state         = r_state;
    assign o_fetch_pc      = r_fetch_pc;

    a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst)
        (r_state == IDLE) |-> !bus.imem_rvalid);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder, decode handshake and redirect scenarios.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    fetch_state_t dbg_state;
    logic [31:0]  dbg_fetch_pc;
    logic [2:0]   dbg_count;
    int           n_cmp = 0;
    int           n_err = 0;
    int           mem_lat = 1;
    int           mem_wait = 0;
    logic [31:0]  mem_addr = '0;
    int           pop_cnt = 0;

    fetch_unit_if bus();

    fetch_unit #(.FQ_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_state    (dbg_state),
        .o_fetch_pc (dbg_fetch_pc),
        .o_count    (dbg_count)
    );

    always #5 clk = ~clk;

    // Memory: accepts at the edge, answers mem_lat cycles later with addr ^ DEAD0000.
    always @(posedge clk) begin
        if (!rst) mem_wait = 0;
        else if (bus.imem_req && bus.imem_ready) begin
            mem_wait = mem_lat;
            mem_addr = bus.imem_addr;
        end else if (mem_wait > 0) mem_wait = mem_wait - 1;
    end

    always @(negedge clk or negedge rst) begin
        bus.imem_rvalid = rst && (mem_wait == 1);
        bus.imem_rdata  = (rst && mem_wait == 1) ? (mem_addr ^ 32'hDEAD_0000) : 32'h0;
    end

    always @(posedge clk) begin
        if (rst && bus.instr_valid && bus.instr_ready && !bus.redirect_en) pop_cnt = pop_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", bus.instr_pc); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
        n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", dbg_count); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rel_req: got %0b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL rel_addr: got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_stream();
        logic        exp_v;
        logic [31:0] exp_pc;
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; mem_lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp_v  = (i >= 2) && (i % 2 == 0);
            exp_pc = 32'((i - 2) * 2);
            n_cmp++; if (bus.instr_valid !== exp_v) begin n_err++; $display("FAIL stream_valid c%0d: got %0b want %0b", i, bus.instr_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (bus.instr_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc c%0d: got %h want %h", i, bus.instr_pc, exp_pc); end
                n_cmp++; if (bus.instr !== (exp_pc ^ 32'hDEAD_0000)) begin n_err++; $display("FAIL stream_instr c%0d: got %h want %h", i, bus.instr, exp_pc ^ 32'hDEAD_0000); end
            end
        end
    endtask

    task automatic test_backpressure();
        int p0;
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b0; mem_lat = 1;
        do_reset();
        p0 = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (i >= 8) begin
                n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL full_req c%0d: got %0b want 0", i, bus.imem_req); end
            end
        end
        n_cmp++; if (dbg_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", dbg_count); end
        n_cmp++; if (pop_cnt !== p0) begin n_err++; $display("FAIL full_pops: got %0d want %0d", pop_cnt, p0); end
        @(negedge clk);
        bus.instr_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid %0d: got %0b want 1", j, bus.instr_valid); end
            n_cmp++; if (bus.instr_pc !== 32'(4 * j)) begin n_err++; $display("FAIL drain_pc %0d: got %h want %h", j, bus.instr_pc, 32'(4 * j)); end
            if (j == 1) begin
                n_cmp++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL resume_req: got %0b/%h want 1/00000010", bus.imem_req, bus.imem_addr); end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus.instr_pc !== 32'h10 || bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL resume_pc: got %0b/%h want 1/00000010", bus.instr_valid, bus.instr_pc); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_ready_stall();
        bus.imem_ready = 1'b0; bus.instr_ready = 1'b1; mem_lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL stall_addr c%0d: got %0b/%h want 1/00000000", i, bus.imem_req, bus.imem_addr); end
            n_cmp++; if (dbg_fetch_pc !== 32'h0) begin n_err++; $display("FAIL stall_fpc c%0d: got %h want 0", i, dbg_fetch_pc); end
        end
        @(negedge clk);
        bus.imem_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL stall_accept_state: got %0d want WAIT", dbg_state); end
        n_cmp++; if (dbg_fetch_pc !== 32'h4) begin n_err++; $display("FAIL stall_accept_fpc: got %h want 4", dbg_fetch_pc); end
    endtask

    task automatic test_redirect_wait();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; mem_lat = 3;
        do_reset();
        @(negedge clk);
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h1002;
        #1;
        n_cmp++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL rdw_state1: got %0d want WAIT", dbg_state); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rdw_req1: got %0b want 0", bus.imem_req); end
        @(negedge clk);
        bus.redirect_en = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== DROP) begin n_err++; $display("FAIL rdw_state2: got %0d want DROP", dbg_state); end
        n_cmp++; if (dbg_fetch_pc !== 32'h1000) begin n_err++; $display("FAIL rdw_fpc: got %h want 00001000", dbg_fetch_pc); end
        @(negedge clk); #1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rdw_valid3: got %0b want 0", bus.instr_valid); end
        @(negedge clk); #1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rdw_dropped: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000) begin n_err++; $display("FAIL rdw_next_addr: got %0b/%h want 1/00001000", bus.imem_req, bus.imem_addr); end
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h1000) begin n_err++; $display("FAIL rdw_new_pc: got %0b/%h want 1/00001000", bus.instr_valid, bus.instr_pc); end
        n_cmp++; if (bus.instr !== 32'hDEAD_1000) begin n_err++; $display("FAIL rdw_new_instr: got %h want dead1000", bus.instr); end
    endtask

    task automatic test_redirect_full();
        int p0;
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b0; mem_lat = 1;
        do_reset();
        repeat (10) @(negedge clk);
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h2000; bus.instr_ready = 1'b1;
        p0 = pop_cnt;
        #1;
        n_cmp++; if (dbg_count !== 3'd4) begin n_err++; $display("FAIL rdf_count: got %0d want 4", dbg_count); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rdf_req: got %0b want 0", bus.imem_req); end
        @(negedge clk);
        bus.redirect_en = 1'b0; bus.instr_ready = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rdf_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL rdf_flushed: got %0d want 0", dbg_count); end
        n_cmp++; if (pop_cnt !== p0) begin n_err++; $display("FAIL rdf_pops: got %0d want %0d", pop_cnt, p0); end
        n_cmp++; if (bus.imem_addr !== 32'h2000 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rdf_addr: got %0b/%h want 1/00002000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_back_to_back();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; mem_lat = 1;
        do_reset();
        @(negedge clk);
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h300;
        @(negedge clk);
        bus.redirect_pc = 32'h404;
        #1;
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL b2b_state: got %0d want IDLE", dbg_state); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (dbg_fetch_pc !== 32'h300) begin n_err++; $display("FAIL b2b_fpc1: got %h want 00000300", dbg_fetch_pc); end
        @(negedge clk);
        bus.redirect_en = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h404) begin n_err++; $display("FAIL b2b_addr: got %0b/%h want 1/00000404", bus.imem_req, bus.imem_addr); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h404) begin n_err++; $display("FAIL b2b_pc: got %0b/%h want 1/00000404", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_pc_wrap();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; mem_lat = 1;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        do_reset();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL wrap_req0: got %0b want 0", bus.imem_req); end
        @(negedge clk);
        bus.redirect_en = 1'b0;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_addr); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pc: got %0b/%h want 1/fffffffc", bus.instr_valid, bus.instr_pc); end
        n_cmp++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_next: got %0b/%h want 1/00000000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b0; mem_lat = 3;
        do_reset();
        @(negedge clk); #1;
        n_cmp++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL rmid_state: got %0d want WAIT", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_ctl: got %0b/%0b want 0/0", bus.imem_req, bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rmid_data: got %h/%h want 0/0", bus.instr, bus.instr_pc); end
        n_cmp++; if (dbg_state !== IDLE || dbg_fetch_pc !== 32'h0) begin n_err++; $display("FAIL rmid_regs: got %0d/%h want IDLE/0", dbg_state, dbg_fetch_pc); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_restart: got %0b/%h want 1/00000000", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        bus.imem_ready  = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_ready_stall();
        test_redirect_wait();
        test_redirect_full();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 FQ_DEPTH, default 4, fetch-queue entries (power of 2, >=2).
REQ-002 RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rdata  input  32  returned instruction word.
REQ-009 imem_rvalid  input  1  imem_rdata valid; earliest one cycle after acceptance.
REQ-010 redirect_en  input  1  pipeline redirect/flush request.
REQ-011 redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-012 instr_valid  output  1  decode-side instruction valid.
REQ-013 instr  output  32  instruction word at queue head.
REQ-014 instr_pc  output  32  PC of instr.
REQ-015 instr_ready  input  1  decode accepts instr this cycle.

Function
REQ-016 FSM states IDLE, WAIT, DROP; at most one outstanding memory request.
REQ-017 IDLE: imem_req=1 iff count<FQ_DEPTH and !redirect_en; imem_addr=fetch_pc, held stable until accepted.
REQ-018 IDLE and imem_req&&imem_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32 wrap), state->WAIT.
REQ-019 WAIT: imem_req=0; imem_rvalid: enqueue {imem_rdata, req_pc}, state->IDLE; else hold.
REQ-020 DROP: imem_req=0; imem_rvalid: response discarded, state->IDLE; else hold.
REQ-021 Queue: FIFO of FQ_DEPTH; instr_valid=(count!=0); instr/instr_pc=head entry, 32'h0 when empty.
REQ-022 Dequeue on instr_valid&&instr_ready; enqueue+dequeue same cycle legal, count unchanged; pointers wrap mod FQ_DEPTH.
REQ-023 Enqueue into full queue impossible by REQ-017 gating; the design SHALL carry an assertion for it.
REQ-024 Latency: request accepted cycle N, rvalid cycle N+k -> instr_valid cycle N+k+1.
REQ-025 Throughput: one instruction per two cycles maximum with single-cycle memory.
REQ-026 redirect_en highest priority: at edge, queue flushed (count=0, pointers=0), fetch_pc<={redirect_pc[31:2],2'b00}.
REQ-027 Redirect cycle: imem_req=0; any instr handshake that cycle is void (not counted).
REQ-028 Redirect transitions: IDLE->IDLE; WAIT&&!rvalid->DROP; WAIT&&rvalid->IDLE (data discarded); DROP&&rvalid->IDLE; DROP&&!rvalid->DROP.
REQ-029 imem_rvalid in IDLE is a protocol error: ignored, assertion fires.
REQ-030 Back-to-back redirects: last one wins; fetch resumes from its target once IDLE.

Reset
REQ-031 rst low asynchronously: state=IDLE, fetch_pc=RESET_PC, req_pc=0, count/pointers=0.
REQ-032 While rst low: imem_req=0, instr_valid=0, instr=0, instr_pc=0; first request (addr RESET_PC) in first cycle after release.
REQ-033 Reset mid-transaction abandons outstanding request; memory shares the same rst.

Structure
REQ-034 Shared package: fetch_state_t enum {IDLE,WAIT,DROP}, fq_entry_t struct {instr[31:0], pc[31:0]}.
REQ-035 Parameters package: FQ_DEPTH default and RESET_PC constant.
REQ-036 One sub-module, fetch_queue: synchronous FIFO with flush input, count, full/empty outputs.

Verification
REQ-037 Reset release, 1-cycle memory, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8, instr_valid every 2nd cycle.
REQ-038 instr_ready=0 for 20 cycles -> exactly FQ_DEPTH=4 entries (pc 0x0..0xC), imem_req=0 thereafter, none lost on resume.
REQ-039 redirect_en, redirect_pc=0x1002 during WAIT, rvalid 3 cycles later -> that data dropped, next imem_addr=0x1000.
REQ-040 Redirect with full queue and instr_ready=1 same cycle -> instr_valid=0 next cycle, no extra dequeue counted.
REQ-041 rst asserted while WAIT -> outputs zero immediately; after release imem_addr=RESET_PC.
REQ-042 imem_ready held 0 five cycles -> imem_addr stable at 0x0, fetch_pc unchanged.
